// File: rtl/spi_tx.sv
// spi_tx: byte-wide SPI mode-0 transmitter, SCLK = clk/4 or clk/8.
// Define SPI_TX_LSB_FIRST_EN to shift bit 0 first instead of bit 7.
module spi_tx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk_divider,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] tx_wr_data,
   output logic              wr_done,
   input  logic              SPI_miso,
   output logic              SPI_mosi,
   output logic              SPI_sclk,
   output logic              SPI_csn
);

   localparam int BW = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              div_q, div_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              csn_q, csn_d;
   logic              done_q, done_d;

   logic              half_end;
   logic              last_bit;
   logic              first_bit;
   logic              next_bit;
   logic [DATA_W-1:0] sh_next;
   logic              unused_miso;

   assign unused_miso = SPI_miso;

   assign half_end = (cnt_q == (div_q ? 2'd3 : 2'd1));
   assign last_bit = (bit_q == BW'(DATA_W - 1));

`ifdef SPI_TX_LSB_FIRST_EN
   assign first_bit = tx_wr_data[0];
   assign next_bit  = sh_q[1];
   assign sh_next   = sh_q >> 1;
`else
   assign first_bit = tx_wr_data[DATA_W-1];
   assign next_bit  = sh_q[DATA_W-2];
   assign sh_next   = sh_q << 1;
`endif

   // State and output registers; reset forces the idle line levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         div_q   <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         csn_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         div_q   <= div_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         csn_q   <= csn_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: each phase lasts H clk cycles, counted by cnt.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      div_d   = div_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      csn_d   = csn_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_en) begin
               sh_d    = tx_wr_data;
               div_d   = sclk_divider;
               csn_d   = 1'b0;
               mosi_d  = first_bit;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (half_end) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         SHIFT: begin
            if (!half_end) begin
               cnt_d = cnt_q + 2'd1;
            end else begin
               cnt_d = '0;
               if (sclk_q) begin
                  // Falling edge: present the next bit, keep the last one.
                  sclk_d = 1'b0;
                  if (!last_bit) begin
                     sh_d   = sh_next;
                     mosi_d = next_bit;
                  end
               end else if (last_bit) begin
                  state_d = HOLD;
               end else begin
                  sclk_d = 1'b1;
                  bit_d  = bit_q + BW'(1);
               end
            end
         end
         HOLD: begin
            if (half_end) begin
               cnt_d   = '0;
               csn_d   = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_done  = done_q;
   assign SPI_mosi = mosi_q;
   assign SPI_sclk = sclk_q;
   assign SPI_csn  = csn_q;

endmodule

// File: tb/tb_spi_tx.sv
// tb_spi_tx: directed bench for spi_tx, samples 1 time unit after posedge.
// Sample index 0 is taken just after the accepting edge E0.
module tb_spi_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk_divider = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] tx_wr_data = 8'h00;
   logic       wr_done;
   logic       SPI_miso = 1'b0;
   logic       SPI_mosi;
   logic       SPI_sclk;
   logic       SPI_csn;

   int checks = 0;
   int failures = 0;

   logic s_sclk [0:127];
   logic s_mosi [0:127];
   logic s_csn  [0:127];
   logic s_done [0:127];
   int   nsamp;

   int         nrise, first_rise, nhigh;
   int         ndone, done0, done1, csnlow, csnhi;
   logic [7:0] b0, b1;

   spi_tx #(.DATA_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sclk_divider (sclk_divider),
      .wr_en        (wr_en),
      .tx_wr_data   (tx_wr_data),
      .wr_done      (wr_done),
      .SPI_miso     (SPI_miso),
      .SPI_mosi     (SPI_mosi),
      .SPI_sclk     (SPI_sclk),
      .SPI_csn      (SPI_csn)
   );

   always #5 clk = ~clk;

   task automatic start(input logic [7:0] d, input logic div);
      @(negedge clk);
      tx_wr_data   = d;
      sclk_divider = div;
      wr_en        = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input int n, input int drop_at,
                          input int pulse_at);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         s_sclk[i] = SPI_sclk;
         s_mosi[i] = SPI_mosi;
         s_csn[i]  = SPI_csn;
         s_done[i] = wr_done;
         if (i == drop_at) wr_en = 1'b0;
         if (i == pulse_at) begin
            wr_en      = 1'b1;
            tx_wr_data = 8'hC3;
         end else if (i == pulse_at + 1) begin
            wr_en = 1'b0;
         end
      end
      nsamp = n;
   endtask

   task automatic analyze();
      nrise = 0; first_rise = -1; nhigh = 0;
      ndone = 0; done0 = -1; done1 = -1;
      csnlow = 0; csnhi = 0; b0 = 8'h00; b1 = 8'h00;
      for (int i = 0; i < nsamp; i++) begin
         if (s_sclk[i]) nhigh++;
         if (i > 0 && s_sclk[i] && !s_sclk[i-1]) begin
            if (nrise == 0) first_rise = i;
            if (nrise < 8) b0 = {b0[6:0], s_mosi[i]};
            else if (nrise < 16) b1 = {b1[6:0], s_mosi[i]};
            nrise++;
         end
         if (s_done[i]) begin
            if (ndone == 0) done0 = i;
            else if (ndone == 1) done1 = i;
            ndone++;
         end
      end
      for (int i = 0; i < nsamp; i++) begin
         if ((done0 < 0 || i < done0) && !s_csn[i]) csnlow++;
         if (done1 >= 0 && i < done1 && s_csn[i]) csnhi++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (SPI_csn !== 1'b1) begin
         failures++; $display("FAIL reset_csn got=%b exp=1", SPI_csn);
      end
      checks++;
      if (SPI_sclk !== 1'b0) begin
         failures++; $display("FAIL reset_sclk got=%b exp=0", SPI_sclk);
      end
      checks++;
      if (SPI_mosi !== 1'b0) begin
         failures++; $display("FAIL reset_mosi got=%b exp=0", SPI_mosi);
      end
      checks++;
      if (wr_done !== 1'b0) begin
         failures++; $display("FAIL reset_done got=%b exp=0", wr_done);
      end
      wr_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_div4_a5();
      start(8'hA5, 1'b0);
      wr_en        = 1'b0;
      sclk_divider = 1'b1;
      capture(45, -10, -10);
      analyze();
      checks++;
      if (b0 !== 8'hA5) begin
         failures++; $display("FAIL a5_bits got=%h exp=a5", b0);
      end
      checks++;
      if (nrise != 8) begin
         failures++; $display("FAIL a5_rises got=%0d exp=8", nrise);
      end
      checks++;
      if (first_rise != 2) begin
         failures++; $display("FAIL a5_first_rise got=%0d exp=2", first_rise);
      end
      checks++;
      if (nhigh != 16) begin
         failures++; $display("FAIL a5_sclk_high got=%0d exp=16", nhigh);
      end
      checks++;
      if (done0 != 36) begin
         failures++; $display("FAIL a5_done_at got=%0d exp=36", done0);
      end
      checks++;
      if (ndone != 1) begin
         failures++; $display("FAIL a5_done_cnt got=%0d exp=1", ndone);
      end
      checks++;
      if (csnlow != 36) begin
         failures++; $display("FAIL a5_csn_low got=%0d exp=36", csnlow);
      end
   endtask

   task automatic test_div8_3c();
      start(8'h3C, 1'b1);
      wr_en = 1'b0;
      capture(80, -10, -10);
      analyze();
      checks++;
      if (b0 !== 8'h3C) begin
         failures++; $display("FAIL 3c_bits got=%h exp=3c", b0);
      end
      checks++;
      if (first_rise != 4) begin
         failures++; $display("FAIL 3c_first_rise got=%0d exp=4", first_rise);
      end
      checks++;
      if (nhigh != 32) begin
         failures++; $display("FAIL 3c_sclk_high got=%0d exp=32", nhigh);
      end
      checks++;
      if (done0 != 72) begin
         failures++; $display("FAIL 3c_done_at got=%0d exp=72", done0);
      end
      checks++;
      if (csnlow != 72) begin
         failures++; $display("FAIL 3c_csn_low got=%0d exp=72", csnlow);
      end
   endtask

   task automatic test_back_to_back();
      start(8'hFF, 1'b0);
      tx_wr_data = 8'h00;
      capture(90, 38, -10);
      analyze();
      checks++;
      if (b0 !== 8'hFF) begin
         failures++; $display("FAIL b2b_byte0 got=%h exp=ff", b0);
      end
      checks++;
      if (b1 !== 8'h00) begin
         failures++; $display("FAIL b2b_byte1 got=%h exp=00", b1);
      end
      checks++;
      if (nrise != 16) begin
         failures++; $display("FAIL b2b_rises got=%0d exp=16", nrise);
      end
      checks++;
      if (ndone != 2 || done0 != 36 || done1 != 73) begin
         failures++;
         $display("FAIL b2b_done got=%0d@%0d,%0d exp=2@36,73",
                  ndone, done0, done1);
      end
      checks++;
      if (csnhi != 1) begin
         failures++; $display("FAIL b2b_csn_gap got=%0d exp=1", csnhi);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic prev;
      int   rises;
      start(8'h5A, 1'b0);
      wr_en = 1'b0;
      prev  = SPI_sclk;
      rises = 0;
      for (int i = 1; i < 40 && rises < 3; i++) begin
         @(posedge clk);
         #1;
         if (SPI_sclk && !prev) rises++;
         prev = SPI_sclk;
      end
      checks++;
      if (rises != 3) begin
         failures++; $display("FAIL rst_mid_rises got=%0d exp=3", rises);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (SPI_csn !== 1'b1) begin
         failures++; $display("FAIL rst_mid_csn got=%b exp=1", SPI_csn);
      end
      checks++;
      if (SPI_sclk !== 1'b0) begin
         failures++; $display("FAIL rst_mid_sclk got=%b exp=0", SPI_sclk);
      end
      checks++;
      if (SPI_mosi !== 1'b0) begin
         failures++; $display("FAIL rst_mid_mosi got=%b exp=0", SPI_mosi);
      end
      checks++;
      if (wr_done !== 1'b0) begin
         failures++; $display("FAIL rst_mid_done got=%b exp=0", wr_done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      capture(40, -10, -10);
      analyze();
      checks++;
      if (ndone != 0 || csnlow != 0) begin
         failures++;
         $display("FAIL rst_mid_quiet got=done%0d,csnlow%0d exp=0,0",
                  ndone, csnlow);
      end
      start(8'h81, 1'b0);
      wr_en = 1'b0;
      capture(45, -10, -10);
      analyze();
      checks++;
      if (b0 !== 8'h81) begin
         failures++; $display("FAIL rst_next_bits got=%h exp=81", b0);
      end
      checks++;
      if (done0 != 36 || ndone != 1) begin
         failures++;
         $display("FAIL rst_next_done got=%0d@%0d exp=1@36", ndone, done0);
      end
   endtask

   task automatic test_ignore_mid_wr();
      start(8'h5A, 1'b0);
      wr_en = 1'b0;
      capture(50, -10, 10);
      analyze();
      checks++;
      if (b0 !== 8'h5A) begin
         failures++; $display("FAIL ign_bits got=%h exp=5a", b0);
      end
      checks++;
      if (ndone != 1 || done0 != 36) begin
         failures++;
         $display("FAIL ign_done got=%0d@%0d exp=1@36", ndone, done0);
      end
      checks++;
      if (nrise != 8) begin
         failures++; $display("FAIL ign_rises got=%0d exp=8", nrise);
      end
   endtask

   task automatic test_bit_order();
      logic [7:0] exp_seq;
`ifdef SPI_TX_LSB_FIRST_EN
      exp_seq = 8'h80;
`else
      exp_seq = 8'h01;
`endif
      start(8'h01, 1'b0);
      wr_en = 1'b0;
      capture(45, -10, -10);
      analyze();
      checks++;
      if (b0 !== exp_seq) begin
         failures++; $display("FAIL order_bits got=%h exp=%h", b0, exp_seq);
      end
   endtask

   initial begin
      test_reset();
      test_div4_a5();
      test_div8_3c();
      test_back_to_back();
      test_reset_mid_frame();
      test_ignore_mid_wr();
      test_bit_order();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
